alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Command-issue and result-capture stage wrapped around the team's ALU (my_alu).
- Accepts one ALU command per valid/ready handshake and drives registered A/B/opcode into the ALU.
- Waits a parameterised ALU latency, captures result and flags, and holds them on a valid/ready response port until consumed.
- Exactly one operation in flight at a time; back-to-back issue is possible on the response-handshake cycle.

Parameters:
- NUMBITS, 8, operand/result width.
- ALU_LAT, 1, rising edges after alu_* outputs change until alu_result/flags reflect them (0 = combinational ALU).
- CNT_W, 16, width of completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted this cycle when high with cmd_valid
- cmd_opcode  in  3  ALU operation
- cmd_a  in  NUMBITS  operand A
- cmd_b  in  NUMBITS  operand B
- alu_A  out  NUMBITS  registered operand A to ALU
- alu_B  out  NUMBITS  registered operand B to ALU
- alu_opcode  out  3  registered opcode to ALU
- alu_result  in  NUMBITS  ALU result
- alu_carryout  in  1  ALU carry
- alu_overflow  in  1  ALU overflow
- alu_zero  in  1  ALU zero flag
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  NUMBITS  captured result
- rsp_flags  out  3  captured {carryout, overflow, zero}
- rsp_opcode  out  3  opcode that produced the response
- busy  out  1  high in WAIT or RESP
- op_count  out  CNT_W  completed responses, wraps modulo 2^CNT_W

Behaviour:
- Reset (reset=0, async): state=IDLE; every output 0 (cmd_ready=0 while asserted, alu_opcode=000, rsp_*=0, op_count=0, internal counter=0). Any in-flight operation is discarded.
- FSM states: IDLE, WAIT, RESP.
- cmd_ready = (state==IDLE) | (state==RESP & rsp_ready). This is combinational from rsp_ready and is documented.
- Accept edge E0 (cmd_valid & cmd_ready): load alu_A/alu_B/alu_opcode from cmd_*, set lat_cnt=ALU_LAT, go WAIT.
- WAIT, each edge: if lat_cnt==0, capture alu_result/flags/opcode into rsp_*, set rsp_valid=1, go RESP; else lat_cnt--.
- Capture therefore occurs at edge E0+ALU_LAT+1; rsp_valid is visible after that edge.
- RESP: rsp_* held stable while rsp_ready=0. New commands are not accepted; alu_* outputs hold.
- RESP with rsp_ready=1 at an edge: op_count++ and rsp_valid=0.
  - If cmd_valid is also high at that edge, accept the new command at the same edge and go WAIT.
  - Otherwise go IDLE.
- alu_* outputs change only on an accept edge. They hold their last values in IDLE.
- cmd_valid in WAIT is ignored (cmd_ready=0). The command is not lost; the producer holds it.
- op_count wraps from 2^CNT_W-1 to 0 with no flag.
- Opcode values pass through unchanged. All 8 encodings are legal, with no decode in this block.

Decomposition:
- Shared package alu_pkg:
  - opcode constants OP_ADDU=000, OP_SUBU=001, OP_ADDS=010, OP_SUBS=011, OP_AND=100, OP_OR=101, OP_XOR=110, OP_DIV2=111.
  - state encoding IDLE/WAIT/RESP.
  - flag bit indices FLG_C=2, FLG_V=1, FLG_Z=0.
- No sub-module. Single FSM plus registers. Bench instantiates alu_issue_ctrl driving my_alu.

Test Plan:
- Hold reset=0 for 2 cycles, then release -> all outputs 0 during reset; cmd_ready=1, busy=0, op_count=0 on the first cycle after release.
- ALU_LAT=1, cmd OP_ADDU A=0xFF B=0x01 accepted at E0 -> alu_A=FF/alu_B=01 after E0; rsp_valid=1 after E2 with rsp_result=0x00, rsp_flags=3'b101, rsp_opcode=000.
- Same op with rsp_ready=0 for 5 cycles and cmd_valid=1 throughout -> rsp_* stable, cmd_ready=0, alu_* unchanged; on rsp_ready=1, op_count=1.
- In RESP with rsp_ready=1 and cmd OP_XOR A=0x0F B=0x3C -> same-edge accept, rsp_valid=0 for 2 cycles, then rsp_result=0x33, rsp_flags=3'b000, op_count increments once per consumed response.
- Assert reset one cycle after accept (in WAIT) -> outputs zero immediately without a clock edge; after release, IDLE with no spurious rsp_valid.
- CNT_W=2, complete 5 ops -> op_count sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/capture stage: opcodes, FSM states, flag bit positions.
package alu_pkg;

    localparam logic [2:0] OP_ADDU = 3'b000;
    localparam logic [2:0] OP_SUBU = 3'b001;
    localparam logic [2:0] OP_ADDS = 3'b010;
    localparam logic [2:0] OP_SUBS = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_DIV2 = 3'b111;

    localparam int unsigned FLG_C = 2;
    localparam int unsigned FLG_V = 1;
    localparam int unsigned FLG_Z = 0;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StWait = 2'b01,
        StResp = 2'b10
    } issue_state_e;

endpackage

// File: rtl/alu_issue_ctrl.sv
// Issues one command at a time to an external ALU, waits ALU_LAT edges, then holds the
// captured result on a valid/ready response port. cmd_ready is combinational from rsp_ready.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned NUMBITS = 8,
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_opcode,
    input  logic [NUMBITS-1:0] cmd_a,
    input  logic [NUMBITS-1:0] cmd_b,
    output logic [NUMBITS-1:0] alu_A,
    output logic [NUMBITS-1:0] alu_B,
    output logic [2:0]         alu_opcode,
    input  logic [NUMBITS-1:0] alu_result,
    input  logic               alu_carryout,
    input  logic               alu_overflow,
    input  logic               alu_zero,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [NUMBITS-1:0] rsp_result,
    output logic [2:0]         rsp_flags,
    output logic [2:0]         rsp_opcode,
    output logic               busy,
    output logic [CNT_W-1:0]   op_count
);

    localparam int unsigned LatW = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

    issue_state_e    state;
    logic [LatW-1:0] lat_cnt;
    logic            accept;

    // Gated by reset so no command is handshaken while reset is held.
    assign cmd_ready = reset & ((state == StIdle) | ((state == StResp) & rsp_ready));
    assign accept    = cmd_valid & cmd_ready;
    assign busy      = (state != StIdle);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= StIdle;
            lat_cnt    <= '0;
            alu_A      <= '0;
            alu_B      <= '0;
            alu_opcode <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_opcode <= '0;
            op_count   <= '0;
        end else begin
            if (accept) begin
                alu_A      <= cmd_a;
                alu_B      <= cmd_b;
                alu_opcode <= cmd_opcode;
                lat_cnt    <= LatW'(ALU_LAT);
            end

            unique case (state)
                StIdle: begin
                    if (cmd_valid) begin
                        state <= StWait;
                    end
                end
                StWait: begin
                    if (lat_cnt == '0) begin
                        rsp_result       <= alu_result;
                        rsp_flags[FLG_C] <= alu_carryout;
                        rsp_flags[FLG_V] <= alu_overflow;
                        rsp_flags[FLG_Z] <= alu_zero;
                        rsp_opcode       <= alu_opcode;
                        rsp_valid        <= 1'b1;
                        state            <= StResp;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        op_count  <= op_count + 1'b1;
                        rsp_valid <= 1'b0;
                        // A waiting command is taken on the same edge the response drains.
                        state     <= cmd_valid ? StWait : StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU models, a response scoreboard, an opcode
// vector table and hand-written sequences for back-pressure, same-edge issue and reset.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int unsigned NB = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // Instance 1: ALU_LAT=1, CNT_W=16
    logic          cmd_valid = 1'b0, cmd_ready;
    logic [2:0]    cmd_opcode = '0;
    logic [NB-1:0] cmd_a = '0, cmd_b = '0;
    logic [NB-1:0] alu_A, alu_B, alu_result;
    logic [2:0]    alu_opcode;
    logic          alu_carryout, alu_overflow, alu_zero;
    logic          rsp_valid, rsp_ready = 1'b0, busy;
    logic [NB-1:0] rsp_result;
    logic [2:0]    rsp_flags, rsp_opcode;
    logic [15:0]   op_count;

    // Instance 2: combinational ALU, 2-bit counter
    logic          d2_cmd_valid = 1'b0, d2_cmd_ready;
    logic [2:0]    d2_cmd_opcode = '0;
    logic [NB-1:0] d2_cmd_a = '0, d2_cmd_b = '0;
    logic [NB-1:0] d2_alu_A, d2_alu_B, d2_alu_result;
    logic [2:0]    d2_alu_opcode;
    logic          d2_alu_carryout, d2_alu_overflow, d2_alu_zero;
    logic          d2_rsp_valid, d2_rsp_ready = 1'b0, d2_busy;
    logic [NB-1:0] d2_rsp_result;
    logic [2:0]    d2_rsp_flags, d2_rsp_opcode;
    logic [1:0]    d2_op_count;

    alu_issue_ctrl #(.NUMBITS(NB), .ALU_LAT(1), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_A(alu_A), .alu_B(alu_B), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_carryout(alu_carryout),
        .alu_overflow(alu_overflow), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_opcode(rsp_opcode),
        .busy(busy), .op_count(op_count)
    );

    alu_issue_ctrl #(.NUMBITS(NB), .ALU_LAT(0), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset),
        .cmd_valid(d2_cmd_valid), .cmd_ready(d2_cmd_ready), .cmd_opcode(d2_cmd_opcode),
        .cmd_a(d2_cmd_a), .cmd_b(d2_cmd_b),
        .alu_A(d2_alu_A), .alu_B(d2_alu_B), .alu_opcode(d2_alu_opcode),
        .alu_result(d2_alu_result), .alu_carryout(d2_alu_carryout),
        .alu_overflow(d2_alu_overflow), .alu_zero(d2_alu_zero),
        .rsp_valid(d2_rsp_valid), .rsp_ready(d2_rsp_ready), .rsp_result(d2_rsp_result),
        .rsp_flags(d2_rsp_flags), .rsp_opcode(d2_rsp_opcode),
        .busy(d2_busy), .op_count(d2_op_count)
    );

    // Reference ALU: returns {carry, overflow, zero, result}
    function automatic logic [NB+2:0] alu_f(input logic [2:0] op, input logic [NB-1:0] a,
                                            input logic [NB-1:0] b);
        logic [NB:0]   s;
        logic [NB-1:0] r;
        logic          c, v;
        s = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            OP_ADDU: begin s = {1'b0, a} + {1'b0, b}; r = s[NB-1:0]; c = s[NB]; end
            OP_SUBU: begin r = a - b; c = (a < b); end
            OP_ADDS: begin
                s = {1'b0, a} + {1'b0, b}; r = s[NB-1:0]; c = s[NB];
                v = (a[NB-1] == b[NB-1]) && (r[NB-1] != a[NB-1]);
            end
            OP_SUBS: begin
                r = a - b; c = (a < b);
                v = (a[NB-1] != b[NB-1]) && (r[NB-1] != a[NB-1]);
            end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = {a[NB-1], a[NB-1:1]};
        endcase
        return {c, v, (r == '0), r};
    endfunction

    always @(posedge clk)
        {alu_carryout, alu_overflow, alu_zero, alu_result} <= alu_f(alu_opcode, alu_A, alu_B);
    assign {d2_alu_carryout, d2_alu_overflow, d2_alu_zero, d2_alu_result} =
        alu_f(d2_alu_opcode, d2_alu_A, d2_alu_B);

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: expectation pushed on command handshake, popped on response handshake
    typedef struct packed {
        logic [2:0]    op;
        logic [2:0]    flags;
        logic [NB-1:0] res;
    } exp_t;
    exp_t sb_q[$];
    exp_t sb_e;

    always @(negedge clk) begin
        if (!reset) begin
            sb_q.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    sb_e = sb_q.pop_front();
                    check("sb_result", 32'(rsp_result), 32'(sb_e.res));
                    check("sb_flags", 32'(rsp_flags), 32'(sb_e.flags));
                    check("sb_opcode", 32'(rsp_opcode), 32'(sb_e.op));
                end
            end
            if (cmd_valid && cmd_ready)
                sb_q.push_back({cmd_opcode, alu_f(cmd_opcode, cmd_a, cmd_b)});
        end
    end

    typedef struct {
        logic [2:0]    op;
        logic [NB-1:0] a;
        logic [NB-1:0] b;
        logic [NB-1:0] res;
        logic [2:0]    flags;
    } vec_t;
    vec_t vecs[8];

    // Drive a command to instance 1 until accepted; returns at accept edge + 1ns.
    task automatic issue(input logic [2:0] op, input logic [NB-1:0] a, input logic [NB-1:0] b);
        int n;
        cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("issue_timeout", 32'(n < 20), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int cnt_seq[5];
        logic [NB+2:0] e2;
        cnt_seq = '{1, 2, 3, 0, 1};

        vecs[0] = '{OP_ADDU, 8'hFF, 8'h01, 8'h00, 3'b101};
        vecs[1] = '{OP_SUBU, 8'h05, 8'h07, 8'hFE, 3'b100};
        vecs[2] = '{OP_ADDS, 8'h7F, 8'h01, 8'h80, 3'b010};
        vecs[3] = '{OP_SUBS, 8'h80, 8'h01, 8'h7F, 3'b010};
        vecs[4] = '{OP_AND,  8'hF0, 8'h0F, 8'h00, 3'b001};
        vecs[5] = '{OP_OR,   8'hA0, 8'h05, 8'hA5, 3'b000};
        vecs[6] = '{OP_XOR,  8'h0F, 8'h3C, 8'h33, 3'b000};
        vecs[7] = '{OP_DIV2, 8'h81, 8'h00, 8'hC0, 3'b000};

        // Reset held for two cycles with a command pending
        cmd_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
            check("rst_outputs", {rsp_valid, busy, alu_opcode, rsp_flags, rsp_opcode},
                  32'd0);
            check("rst_data", {alu_A, alu_B, rsp_result}, 32'd0);
            check("rst_op_count", 32'(op_count), 32'd0);
        end
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_count", 32'(op_count), 32'd0);
        @(posedge clk); #1;

        // ADDU FF+01, capture two edges after accept
        issue(OP_ADDU, 8'hFF, 8'h01);
        check("e0_alu_A", 32'(alu_A), 32'hFF);
        check("e0_alu_B", 32'(alu_B), 32'h01);
        check("e0_alu_op", 32'(alu_opcode), 32'(OP_ADDU));
        check("e0_busy", 32'(busy), 32'd1);
        check("e0_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        check("e1_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("e2_rsp_valid", 32'(rsp_valid), 32'd1);
        check("e2_rsp_result", 32'(rsp_result), 32'h00);
        check("e2_rsp_flags", 32'(rsp_flags), 32'b101);
        check("e2_rsp_opcode", 32'(rsp_opcode), 32'(OP_ADDU));

        // Back-pressure with a pending command, then same-edge drain and issue
        cmd_valid = 1'b1; cmd_opcode = OP_XOR; cmd_a = 8'h0F; cmd_b = 8'h3C;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_result", 32'(rsp_result), 32'h00);
            check("hold_flags", 32'(rsp_flags), 32'b101);
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            check("hold_alu_A", 32'(alu_A), 32'hFF);
        end
        rsp_ready = 1'b1;
        #1;
        check("drain_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        check("b2b_op_count", 32'(op_count), 32'd1);
        check("b2b_rsp_valid0", 32'(rsp_valid), 32'd0);
        check("b2b_alu", {alu_opcode, alu_A, alu_B}, {13'd0, OP_XOR, 8'h0F, 8'h3C});
        @(posedge clk); #1;
        check("b2b_rsp_valid1", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("b2b_rsp_valid2", 32'(rsp_valid), 32'd1);
        check("b2b_result", 32'(rsp_result), 32'h33);
        check("b2b_flags", 32'(rsp_flags), 32'b000);
        consume();
        check("b2b_op_count2", 32'(op_count), 32'd2);
        check("b2b_idle", 32'(busy), 32'd0);

        // One vector per opcode
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_rsp(lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
            check($sformatf("vec%0d_result", i), 32'(rsp_result), 32'(vecs[i].res));
            check($sformatf("vec%0d_flags", i), 32'(rsp_flags), 32'(vecs[i].flags));
            check($sformatf("vec%0d_opcode", i), 32'(rsp_opcode), 32'(vecs[i].op));
            consume();
        end
        check("vec_op_count", 32'(op_count), 32'd10);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        // Asynchronous reset while WAIT
        issue(OP_ADDU, 8'h01, 8'h01);
        check("wait_busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_busy", 32'(busy), 32'd0);
        check("async_alu", {alu_opcode, alu_A, alu_B}, 32'd0);
        check("async_cmd_ready", 32'(cmd_ready), 32'd0);
        check("async_count", 32'(op_count), 32'd0);
        check("async_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("post_async_rsp_valid", 32'(rsp_valid), 32'd0);
            check("post_async_busy", 32'(busy), 32'd0);
            check("post_async_ready", 32'(cmd_ready), 32'd1);
        end

        // Combinational ALU, 2-bit counter wrap
        for (int i = 0; i < 5; i++) begin
            d2_cmd_valid = 1'b1;
            d2_cmd_opcode = 3'(i);
            d2_cmd_a = 8'($urandom);
            d2_cmd_b = 8'($urandom);
            e2 = alu_f(d2_cmd_opcode, d2_cmd_a, d2_cmd_b);
            @(negedge clk);
            check("d2_cmd_ready", 32'(d2_cmd_ready), 32'd1);
            @(posedge clk); #1;
            d2_cmd_valid = 1'b0;
            check("d2_e0_rsp_valid", 32'(d2_rsp_valid), 32'd0);
            @(posedge clk); #1;
            check("d2_e1_rsp_valid", 32'(d2_rsp_valid), 32'd1);
            check("d2_result", {d2_rsp_flags, d2_rsp_result}, 32'(e2));
            check("d2_opcode", 32'(d2_rsp_opcode), 32'(i));
            d2_rsp_ready = 1'b1;
            @(posedge clk); #1;
            d2_rsp_ready = 1'b0;
            check($sformatf("d2_op_count%0d", i), 32'(d2_op_count), 32'(cnt_seq[i]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
